// File: rtl/sram_controller.sv
// MEM-stage SRAM controller: splits each 32-bit word access into two 16-bit SRAM
// accesses, each held for ACCESS_CYCLES cycles, and stalls the pipeline via ready.
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  localparam logic [3:0]  LastCnt  = 4'(ACCESS_CYCLES - 1);
  localparam logic [31:0] BaseAddr = 32'(BASE_ADDR);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [16:0] offset_q, offset_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        we_n_q, we_n_d;
  logic [31:0] offset_full;
  logic        last_cycle;
  logic        drive_dq;
  logic [15:0] dq_out;
  logic        unused_offset_bits;

  // Offset wraps modulo 2^19; byte-lane bits are dropped (word-aligned only).
  assign offset_full        = address - BaseAddr;
  assign unused_offset_bits = ^{offset_full[31:19], offset_full[1:0]};
  assign last_cycle         = (cnt_q == LastCnt);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    ready       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rd_en || wr_en) begin
          op_wr_d  = wr_en;
          offset_d = offset_full[18:2];
          wdata_d  = write_data;
          cnt_d    = 4'd0;
          state_d  = StLow;
        end else begin
          ready = 1'b1;
        end
      end
      StLow: begin
        if (last_cycle) begin
          if (!op_wr_q) read_data_d[15:0] = SRAM_DQ;
          cnt_d   = 4'd0;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHigh: begin
        if (last_cycle) begin
          if (!op_wr_q) read_data_d[31:16] = SRAM_DQ;
          cnt_d   = 4'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Registered from next state so the strobe is glitch-free and aligned with state_q.
    we_n_d = !(op_wr_d && ((state_d == StLow) || (state_d == StHigh)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      op_wr_q     <= 1'b0;
      offset_q    <= 17'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      we_n_q      <= we_n_d;
    end
  end

  always_comb begin
    SRAM_ADDR = 18'd0;
    dq_out    = wdata_q[15:0];
    drive_dq  = 1'b0;
    unique case (state_q)
      StLow: begin
        SRAM_ADDR = {offset_q, 1'b0};
        drive_dq  = op_wr_q;
      end
      StHigh: begin
        SRAM_ADDR = {offset_q, 1'b1};
        dq_out    = wdata_q[31:16];
        drive_dq  = op_wr_q;
      end
      default: ;
    endcase
  end

  assign SRAM_DQ   = drive_dq ? dq_out : 16'hzzzz;
  assign SRAM_WE_N = we_n_q;
  assign read_data = read_data_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: default-timing DUT against a behavioural
// SRAM model, plus an ACCESS_CYCLES=1 instance against a fixed-pattern memory.
module tb_sram_controller;

  localparam int unsigned AC   = 3;
  localparam int unsigned BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, ub_n, lb_n, ce_n, oe_n;

  logic        wr_en1, rd_en1;
  logic [31:0] address1, write_data1;
  logic [31:0] read_data1;
  logic        ready1;
  wire  [15:0] sram_dq1;
  logic [17:0] sram_addr1;
  logic        we_n1, ub_n1, lb_n1, ce_n1, oe_n1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  logic [15:0] mem [1024];
  int          wcnt = 0;
  logic [17:0] wlast = '0;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1), .SRAM_DQ(sram_dq1),
    .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we_n1), .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1),
    .SRAM_CE_N(ce_n1), .SRAM_OE_N(oe_n1)
  );

  // SRAM drives the bus whenever not being written; a cell only commits after a full
  // AC-cycle write pulse at one address, so an aborted half leaves the old value.
  assign sram_dq  = we_n ? mem[sram_addr[9:0]] : 16'hzzzz;
  assign sram_dq1 = we_n1 ? {sram_addr1[7:0], ~sram_addr1[7:0]} : 16'hzzzz;

  always @(posedge clk) begin
    if (!we_n) begin
      if (wcnt > 0 && sram_addr == wlast) wcnt = wcnt + 1;
      else wcnt = 1;
      wlast = sram_addr;
      if (wcnt == AC) mem[sram_addr[9:0]] <= sram_dq;
    end else begin
      wcnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [17:0] base, input bit hold);
    int k;
    bit done;
    @(posedge clk); #1;
    wr_en = wr; rd_en = !wr; address = a; write_data = wd;
    k = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
        check("busy_cycles", k, 2 * AC + 1);
        check("we_n_done", {31'd0, we_n}, 32'd1);
        if (!wr) begin
          if (exp_q.size() > 0) check("rd_word", read_data, exp_q.pop_front());
          else check("rd_queue_empty", 32'(exp_q.size()), 32'd1);
          last_rd = read_data;
        end else begin
          check("rd_hold_on_wr", read_data, last_rd);
        end
      end else begin
        if (k >= 1) begin
          check("sram_addr", {14'd0, sram_addr}, {14'd0, (k <= AC) ? base : base + 18'd1});
          check("we_n", {31'd0, we_n}, {31'd0, !wr});
          if (wr) check("dq_wr", {16'd0, sram_dq}, {16'd0, (k <= AC) ? wd[15:0] : wd[31:16]});
          else check("dq_rd_released", {16'd0, sram_dq}, {16'd0, mem[sram_addr[9:0]]});
        end
        k++;
        @(posedge clk); #1;
        if (!hold) begin
          wr_en = 1'b0; rd_en = 1'b0; address = '1; write_data = 32'd0;
        end
      end
    end
    check("access_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int k;
    bit done;
    rst = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = 32'd0; write_data1 = 32'd0;
    last_rd = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
    mem[0] = 16'h1357; mem[1] = 16'h2468;
    mem[6] = 16'hAAAA; mem[7] = 16'hBBBB;
    mem[10'h200] = 16'hCAFE; mem[10'h201] = 16'hF00D;

    repeat (2) begin
      @(negedge clk);
      check("rst_read_data", read_data, 32'd0);
      check("rst_we_n", {31'd0, we_n}, 32'd1);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, we_n}, 32'd1);
      check("idle_dq_released", {16'd0, sram_dq}, 32'h1357);
    end

    run_access(1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 1'b0);
    check("mem_lo_written", {16'd0, mem[2]}, 32'hBEEF);
    check("mem_hi_written", {16'd0, mem[3]}, 32'hDEAD);

    exp_q.push_back(32'hDEADBEEF);
    run_access(1'b0, 32'd1028, 32'd0, 18'd2, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    run_access(1'b0, 32'd1031, 32'd0, 18'd2, 1'b0);
    exp_q.push_back(32'hF00DCAFE);
    run_access(1'b0, 32'd0, 32'd0, 18'h3FE00, 1'b0);

    // Read held through DONE, then a write issued on the very next IDLE cycle.
    exp_q.push_back(32'h24681357);
    run_access(1'b0, 32'd1024, 32'd0, 18'd0, 1'b1);
    run_access(1'b1, 32'd1032, 32'h0BADF00D, 18'd4, 1'b0);
    check("b2b_mem_lo", {16'd0, mem[4]}, 32'hF00D);
    check("b2b_mem_hi", {16'd0, mem[5]}, 32'h0BAD);
    repeat (3) begin
      @(negedge clk);
      check("no_replay_ready", {31'd0, ready}, 32'd1);
      check("no_replay_we_n", {31'd0, we_n}, 32'd1);
    end

    // Abort a write during its second high-half cycle.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1036; write_data = 32'h12345678;
    @(posedge clk); #1;
    wr_en = 1'b0; address = '1; write_data = 32'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_we_n", {31'd0, we_n}, 32'd1);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_sram_addr", {14'd0, sram_addr}, 32'd0);
    check("abort_read_data", read_data, 32'd0);
    check("abort_dq_released", {16'd0, sram_dq}, 32'h1357);
    @(posedge clk); #1 rst = 1'b1;
    check("abort_mem_lo", {16'd0, mem[6]}, 32'h5678);
    check("abort_mem_hi", {16'd0, mem[7]}, 32'hBBBB);
    exp_q.push_back(32'hBBBB5678);
    run_access(1'b0, 32'd1036, 32'd0, 18'd6, 1'b0);

    // ACCESS_CYCLES=1 instance: offset 16 -> halves 8/9.
    exp_q.push_back(32'h09F608F7);
    @(posedge clk); #1;
    rd_en1 = 1'b1; address1 = 32'd1040;
    k = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      @(negedge clk);
      if (ready1) begin
        done = 1'b1;
        check("ac1_busy_cycles", k, 32'd3);
        if (exp_q.size() > 0) check("ac1_rd_word", read_data1, exp_q.pop_front());
        else check("ac1_queue_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        k++;
        @(posedge clk); #1;
        rd_en1 = 1'b0; address1 = '1;
      end
    end
    check("ac1_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- MEM-stage controller between the pipeline and the external 16-bit SRAM.
- Turns a 32-bit word read/write from EXE/MEM into two sequential half-word SRAM accesses with programmable wait states.
- Returns the assembled read word as Mem_read_value for the MEM/WB register.
- Drives ready, which the hazard/freeze logic inverts into the pipeline-wide freeze, so EXE/MEM and MEM/WB hold during an access.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0; subtracted before translation.
- ACCESS_CYCLES, 3: cycles each half-word access is held on the SRAM bus (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; state is cleared while rst=0.
- wr_en  in  1  MEM write request (from MEM_W_en).
- rd_en  in  1  MEM read request (from MEM_R_en).
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  assembled read word, to MEM/WB Mem_read_value_in.
- ready  out  1  1 = no access pending or access finishing this cycle; freeze = ~ready.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_WE_N  out  1  SRAM write enable, active-low.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied constant 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, latched request cleared.
  - read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z, ready=1.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If rd_en|wr_en: latch op (write wins if both set; both set is illegal upstream), offset = address-BASE_ADDR, and write_data. ready=0 (combinational). Next state LOW, counter=0.
  - Otherwise ready=1 and the FSM stays in IDLE.
- LOW:
  - SRAM_ADDR = {offset[18:2],1'b0}.
  - Write: SRAM_DQ = wdata[15:0], SRAM_WE_N=0.
  - Read: SRAM_DQ=Z, SRAM_WE_N=1.
  - Counter increments each cycle. On the cycle counter==ACCESS_CYCLES-1: a read registers SRAM_DQ into read_data[15:0]; next state HIGH, counter=0.
  - ready=0.
- HIGH:
  - Same as LOW, with SRAM_ADDR = {offset[18:2],1'b1} and data wdata[31:16].
  - A read captures into read_data[31:16] on the final cycle. Next state DONE. ready=0.
- DONE:
  - ready=1, SRAM_WE_N=1, SRAM_DQ=Z. The pipeline advances on this edge. Next state IDLE unconditionally.
  - A request present in DONE is not restarted. A new request is only accepted in IDLE on the following cycle.
- Latency: ready is low for 2*ACCESS_CYCLES+1 cycles, counted from the first cycle the request is seen in IDLE. With the default, ready=0 for 7 cycles and 1 on the 8th.
- read_data:
  - Holds its last value between reads; writes do not change it.
  - During a read, bits [15:0] update one half-access before bits [31:16]. Consumers sample only when ready=1.
- Address translation: bits [1:0] are ignored (word-aligned access only). Addresses below BASE_ADDR wrap modulo 2^19 with no error.
- Latched request fields are stable for the whole access, even if inputs change.
- Reset asserted mid-access:
  - Immediate return to IDLE; WE_N and DQ are released in the same instant.
  - A half-completed write leaves SRAM partially updated; this is acceptable.
  - read_data=0.
- SRAM_WE_N is registered from the next state, so it has no glitches. SRAM_DQ is driven only in LOW/HIGH of a write.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1 with rd_en=wr_en=0 -> read_data=0, WE_N=1, DQ=Z, ready=1 every cycle.
- Write: wr_en=1, address=1028, write_data=32'hDEADBEEF -> SRAM_ADDR=2, DQ=16'hBEEF, WE_N=0 for 3 cycles; then SRAM_ADDR=3, DQ=16'hDEAD for 3 cycles; ready=0 for 7 cycles, 1 on the 8th.
- Read-back: SRAM model holds halves 2/3 = BEEF/DEAD; rd_en=1, address=1028 -> WE_N=1, DQ=Z from controller; read_data=32'hDEADBEEF when ready=1.
- Back-to-back: read 1024 followed immediately by write 1032 -> one DONE then one IDLE-accept cycle between accesses; second access starts on SRAM_ADDR=4; no request is replayed.
- Reset mid-access: rst=0 during the 2nd HIGH cycle of a write -> WE_N=1 and DQ=Z asynchronously, ready=1, state IDLE; the next read of that address returns the new low half and the old high half.
- ACCESS_CYCLES=1 override: read -> ready=0 for exactly 3 cycles; both halves captured correctly.
